layer_sequencer: RTL and testbench
==================================

Name: layer_sequencer

Overview:
- Top-level scheduler for the accelerator datapath.
- Walks a programmed list of layers and pulses the start of the matching layer controller (conv, pool or dense). It waits for that controller's done, then flips the BUF1/BUF2 ping-pong select before the next layer.
- Sits between the regfile and the per-layer controllers. It owns aybz_azby, so no individual controller drives it.

Parameters:
- MAX_LAYERS, 16, depth of the layer-type table.
- LOG_MAX_LAYERS, 4, index width; equals clog2(MAX_LAYERS).
- TIMEOUT_W, 24, width of the per-layer watchdog counter.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- cfg_we  input  1  write strobe for the layer table
- cfg_addr  input  LOG_MAX_LAYERS  table entry index
- cfg_type  input  2  layer type: 00 conv, 01 pool, 10 dense, 11 nop
- num_layers  input  LOG_MAX_LAYERS+1  layers to run; valid range 1..MAX_LAYERS
- run_start  input  1  start-of-network pulse
- conv_start / pool_start / dense_start  output  1 each  one-cycle start pulse to each controller
- conv_done / pool_done / dense_done  input  1 each  done pulse from each controller
- aybz_azby  output  2  buffer direction: 01 = read BUF1, write BUF2; 10 = read BUF2, write BUF1
- busy  output  1  high from accepted run_start until FINISH or ERROR
- layer_idx  output  LOG_MAX_LAYERS  index of the current layer
- net_done  output  1  one-cycle pulse when all layers complete
- timeout_err  output  1  sticky watchdog error flag

Behaviour:
- Reset values:
  - all start outputs, busy, net_done and timeout_err are 0
  - layer_idx is 0
  - aybz_azby is 01
  - state is IDLE
  - table contents are not reset
- Table write: synchronous, allowed only in IDLE or ERROR. A cfg_we in any other state is ignored.
- IDLE: on run_start with 1 ≤ num_layers ≤ MAX_LAYERS:
  - layer_idx ← 0, aybz_azby ← 01, timeout_err ← 0, busy ← 1
  - go to LAUNCH
  - run_start with num_layers = 0 or > MAX_LAYERS is ignored.
- LAUNCH (1 cycle): assert exactly one start output, chosen by table[layer_idx]; clear the watchdog.
  - type 11 (nop): assert no start and go directly to NEXT without a buffer swap.
  - Otherwise go to WAIT.
  - A done input arriving during LAUNCH is ignored.
- WAIT: watchdog increments every cycle.
  - The done of the selected controller moves the FSM to SWAP.
  - Done from a non-selected controller is ignored.
  - If the watchdog reaches all-ones, go to ERROR.
- SWAP (1 cycle): aybz_azby ← 01 if it was 10, else 10. Go to NEXT.
- NEXT (1 cycle):
  - If layer_idx == num_layers−1, go to FINISH.
  - Otherwise layer_idx ← layer_idx+1 and go to LAUNCH.
- FINISH (1 cycle): net_done = 1, busy ← 0, go to IDLE. aybz_azby and layer_idx hold their final values.
- ERROR: timeout_err = 1 and busy = 0. Stays here until run_start, which behaves as it does in IDLE.
- Latency:
  - start pulse appears one cycle after run_start is accepted
  - per non-nop layer overhead is 3 cycles (LAUNCH, SWAP, NEXT) plus controller time
  - nop layer costs 2 cycles
- run_start while busy: ignored.
- num_layers and the table are sampled live; software must hold them stable while busy.
- Reset mid-run: asynchronous return to reset values. Start pulses must never be partial.

Decomposition:
- Shared package holds:
  - the layer-type enum (LT_CONV, LT_POOL, LT_DENSE, LT_NOP)
  - the sequencer-state enum (IDLE, LAUNCH, WAIT, SWAP, NEXT, FINISH, ERROR)
  - the aybz_azby encodings BUF1_TO_BUF2 = 01 and BUF2_TO_BUF1 = 10
- One sub-module: seq_watchdog, a TIMEOUT_W-bit counter with clear, enable and saturation flag.

Test Plan:
- Table {conv, pool, dense}, num_layers = 3, controller models return done after 10 cycles:
  - exactly one start pulse per layer
  - aybz_azby sequence 01 → 10 → 01 → 10
  - net_done pulses once; busy falls on the same edge.
- Table {pool, nop, pool}:
  - nop consumes 2 cycles with no start pulse and no swap
  - second pool sees aybz_azby = 10.
- During WAIT on pool, pulse conv_done and dense_done:
  - both ignored, FSM stays in WAIT
  - pool_done then advances the FSM.
- Set TIMEOUT_W = 4 and withhold done:
  - ERROR after 15 WAIT cycles, timeout_err = 1, busy = 0
  - a following run_start clears timeout_err and restarts from layer 0.
- run_start while busy, and cfg_we while busy:
  - both ignored; the table entry is unchanged when read back via behaviour on the next run.
- Assert rst during WAIT of layer 2:
  - all outputs return to reset values asynchronously
  - a new run restarts at layer_idx 0 with aybz_azby = 01.

Source files
------------

// File: rtl/layer_sequencer_pkg.sv
// Shared types for the layer sequencer: layer-type and FSM-state enums,
// plus the ping-pong buffer direction encodings.
package layer_sequencer_pkg;

    typedef enum logic [1:0] {
        LT_CONV  = 2'b00,
        LT_POOL  = 2'b01,
        LT_DENSE = 2'b10,
        LT_NOP   = 2'b11
    } layer_type_e;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        SWAP,
        NEXT,
        FINISH,
        ERROR
    } seq_state_e;

    localparam logic [1:0] BUF1_TO_BUF2 = 2'b01;
    localparam logic [1:0] BUF2_TO_BUF1 = 2'b10;

    // Any value other than BUF2_TO_BUF1 flips towards it, so a corrupted
    // direction always recovers to a legal encoding on the next swap.
    function automatic logic [1:0] swap_dir(input logic [1:0] dir);
        return (dir == BUF2_TO_BUF1) ? BUF1_TO_BUF2 : BUF2_TO_BUF1;
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Per-layer watchdog: saturating up-counter with synchronous clear.
// expired is high on the cycle whose increment reaches all-ones, and stays high while saturated.
module seq_watchdog #(
    parameter int TIMEOUT_W = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam logic [TIMEOUT_W-1:0] ALL_ONES  = '1;
    localparam logic [TIMEOUT_W-1:0] LAST_STEP = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    logic [TIMEOUT_W-1:0] count_q, count_d;

    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en && (count_q != ALL_ONES)) begin
            count_d = count_q + 1'b1;
        end
    end

    assign expired = (count_q == ALL_ONES) || (en && (count_q == LAST_STEP));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/layer_sequencer.sv
// Top-level layer scheduler: walks the programmed layer table, launches the
// matching controller, waits for its done and flips the BUF1/BUF2 direction.
module layer_sequencer
    import layer_sequencer_pkg::*;
#(
    parameter int MAX_LAYERS     = 16,
    parameter int LOG_MAX_LAYERS = 4,
    parameter int TIMEOUT_W      = 24
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_we,
    input  logic [LOG_MAX_LAYERS-1:0] cfg_addr,
    input  logic [1:0]                cfg_type,
    input  logic [LOG_MAX_LAYERS:0]   num_layers,
    input  logic                      run_start,
    output logic                      conv_start,
    output logic                      pool_start,
    output logic                      dense_start,
    input  logic                      conv_done,
    input  logic                      pool_done,
    input  logic                      dense_done,
    output logic [1:0]                aybz_azby,
    output logic                      busy,
    output logic [LOG_MAX_LAYERS-1:0] layer_idx,
    output logic                      net_done,
    output logic                      timeout_err
);

    localparam logic [LOG_MAX_LAYERS:0]   NUM_MAX = (LOG_MAX_LAYERS+1)'(MAX_LAYERS);
    localparam logic [LOG_MAX_LAYERS:0]   NUM_ONE = (LOG_MAX_LAYERS+1)'(1);
    localparam logic [LOG_MAX_LAYERS-1:0] IDX_ONE = LOG_MAX_LAYERS'(1);

    seq_state_e                state_q, state_d;
    logic [LOG_MAX_LAYERS-1:0] layer_idx_q, layer_idx_d;
    logic [1:0]                aybz_azby_q, aybz_azby_d;
    layer_type_e               table_q [MAX_LAYERS];

    layer_type_e cur_type;
    logic        table_we;
    logic        num_ok;
    logic        last_layer;
    logic        sel_done;
    logic        wd_clear;
    logic        wd_en;
    logic        wd_expired;

    assign cur_type   = table_q[layer_idx_q];
    assign num_ok     = (num_layers != '0) && (num_layers <= NUM_MAX);
    assign last_layer = ({1'b0, layer_idx_q} == (num_layers - NUM_ONE));

    // Only the controller that was launched can end the WAIT.
    always_comb begin
        sel_done = 1'b0;
        case (cur_type)
            LT_CONV:  sel_done = conv_done;
            LT_POOL:  sel_done = pool_done;
            LT_DENSE: sel_done = dense_done;
            default:  sel_done = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        layer_idx_d = layer_idx_q;
        aybz_azby_d = aybz_azby_q;
        table_we    = 1'b0;
        wd_clear    = 1'b0;
        wd_en       = 1'b0;
        conv_start  = 1'b0;
        pool_start  = 1'b0;
        dense_start = 1'b0;

        case (state_q)
            IDLE, ERROR: begin
                table_we = cfg_we;
                if (run_start && num_ok) begin
                    state_d     = LAUNCH;
                    layer_idx_d = '0;
                    aybz_azby_d = BUF1_TO_BUF2;
                end
            end
            LAUNCH: begin
                wd_clear = 1'b1;
                case (cur_type)
                    LT_CONV:  conv_start  = 1'b1;
                    LT_POOL:  pool_start  = 1'b1;
                    LT_DENSE: dense_start = 1'b1;
                    default:  ;
                endcase
                state_d = (cur_type == LT_NOP) ? NEXT : WAIT;
            end
            WAIT: begin
                wd_en = 1'b1;
                if (sel_done) begin
                    state_d = SWAP;
                end else if (wd_expired) begin
                    state_d = ERROR;
                end
            end
            SWAP: begin
                aybz_azby_d = swap_dir(aybz_azby_q);
                state_d     = NEXT;
            end
            NEXT: begin
                if (last_layer) begin
                    state_d = FINISH;
                end else begin
                    layer_idx_d = layer_idx_q + IDX_ONE;
                    state_d     = LAUNCH;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    seq_watchdog #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .en      (wd_en),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            layer_idx_q <= '0;
            aybz_azby_q <= BUF1_TO_BUF2;
        end else begin
            state_q     <= state_d;
            layer_idx_q <= layer_idx_d;
            aybz_azby_q <= aybz_azby_d;
        end
    end

    // NOTE: the layer table is plain storage with no reset; software programs it before a run.
    always_ff @(posedge clk) begin
        if (table_we) begin
            table_q[cfg_addr] <= layer_type_e'(cfg_type);
        end
    end

    // Start pulses and status decode straight from registered state, so
    // an asynchronous reset removes them immediately with the state.
    assign busy        = state_q inside {LAUNCH, WAIT, SWAP, NEXT};
    assign net_done    = (state_q == FINISH);
    assign timeout_err = (state_q == ERROR);
    assign layer_idx   = layer_idx_q;
    assign aybz_azby   = aybz_azby_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer: controller models answer start
// pulses after programmed delays; expected timing comes from layer cost rules.
module tb_layer_sequencer;

    localparam int MAXL = 16;
    localparam int LOGL = 4;
    localparam int TW   = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cfg_we = 1'b0;
    logic [LOGL-1:0] cfg_addr = '0;
    logic [1:0]      cfg_type = '0;
    logic [LOGL:0]   num_layers = '0;
    logic            run_start = 1'b0;
    logic            conv_start, pool_start, dense_start;
    logic            conv_done, pool_done, dense_done;
    logic [1:0]      aybz_azby;
    logic            busy;
    logic [LOGL-1:0] layer_idx;
    logic            net_done;
    logic            timeout_err;

    logic auto_conv = 1'b0, auto_pool = 1'b0, auto_dense = 1'b0;
    logic inj_conv = 1'b0, inj_pool = 1'b0, inj_dense = 1'b0;
    assign conv_done  = auto_conv  | inj_conv;
    assign pool_done  = auto_pool  | inj_pool;
    assign dense_done = auto_dense | inj_dense;

    always #5 clk = ~clk;

    layer_sequencer #(
        .MAX_LAYERS     (MAXL),
        .LOG_MAX_LAYERS (LOGL),
        .TIMEOUT_W      (TW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_type    (cfg_type),
        .num_layers  (num_layers),
        .run_start   (run_start),
        .conv_start  (conv_start),
        .pool_start  (pool_start),
        .dense_start (dense_start),
        .conv_done   (conv_done),
        .pool_done   (pool_done),
        .dense_done  (dense_done),
        .aybz_azby   (aybz_azby),
        .busy        (busy),
        .layer_idx   (layer_idx),
        .net_done    (net_done),
        .timeout_err (timeout_err)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference copy of the table and per-start controller latencies (0 = never answer).
    logic [1:0] tbl [MAXL];
    int         delays [64];
    logic       tb_clear = 1'b0;

    // Monitor / controller model, sampled on the falling edge.
    int         nrec = 0;
    logic [1:0] rec_type [64];
    int         rec_cyc  [64];
    logic [1:0] rec_dir  [64];
    logic [3:0] rec_idx  [64];
    int         multi_err = 0;
    int         done_cnt  = 0;
    int         done_cyc  = 0;
    logic       busy_at_done = 1'b0;
    logic       pend_valid = 1'b0;
    logic [1:0] pend_type = 2'b00;
    int         pend_at = 0;

    always @(negedge clk) begin
        logic [1:0] t;
        auto_conv  = 1'b0;
        auto_pool  = 1'b0;
        auto_dense = 1'b0;
        if (rst || tb_clear) begin
            pend_valid = 1'b0;
            if (tb_clear) begin
                nrec = 0;
                multi_err = 0;
                done_cnt = 0;
            end
        end else begin
            if (pend_valid && cyc == pend_at) begin
                case (pend_type)
                    2'd0:    auto_conv  = 1'b1;
                    2'd1:    auto_pool  = 1'b1;
                    default: auto_dense = 1'b1;
                endcase
                pend_valid = 1'b0;
            end
            if (conv_start || pool_start || dense_start) begin
                if ($countones({conv_start, pool_start, dense_start}) != 1) multi_err++;
                t = conv_start ? 2'd0 : (pool_start ? 2'd1 : 2'd2);
                if (nrec < 64) begin
                    rec_type[nrec] = t;
                    rec_cyc[nrec]  = cyc;
                    rec_dir[nrec]  = aybz_azby;
                    rec_idx[nrec]  = layer_idx;
                    if (delays[nrec] > 0) begin
                        pend_valid = 1'b1;
                        pend_type  = t;
                        pend_at    = cyc + delays[nrec];
                    end
                end
                nrec++;
            end
            if (net_done) begin
                done_cnt++;
                done_cyc = cyc;
                busy_at_done = busy;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_table(input int addr, input logic [1:0] typ);
        cfg_addr = LOGL'(addr);
        cfg_type = typ;
        cfg_we   = 1'b1;
        tick();
        cfg_we   = 1'b0;
        tbl[addr] = typ;
    endtask

    task automatic clear_monitor();
        tick();
        tb_clear = 1'b1;
        tick();
        tb_clear = 1'b0;
    endtask

    // Runs n layers and checks every start, the buffer direction seen by each
    // layer, the net_done cycle and the final status against the cost rules.
    task automatic run_network(input string name, input int n);
        int         t_launch;
        int         cost;
        int         nst;
        int         exp_cyc  [16];
        logic [1:0] exp_type [16];
        int         exp_idx  [16];
        logic [1:0] exp_dir  [16];
        logic [1:0] final_dir;

        clear_monitor();
        num_layers = (LOGL+1)'(n);
        run_start  = 1'b1;
        tick();
        run_start  = 1'b0;
        t_launch   = cyc;

        n_tests++;
        if (busy !== 1'b1 || timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s accept: busy=%0b timeout_err=%0b, required 1/0", name, busy, timeout_err);
        end

        cost = 0;
        nst  = 0;
        for (int i = 0; i < n; i++) begin
            if (tbl[i] == 2'b11) begin
                cost += 2;
            end else begin
                exp_type[nst] = tbl[i];
                exp_cyc[nst]  = t_launch + cost;
                exp_idx[nst]  = i;
                exp_dir[nst]  = (nst % 2 == 0) ? 2'b01 : 2'b10;
                cost += 3 + delays[nst];
                nst++;
            end
        end
        final_dir = (nst % 2 == 0) ? 2'b01 : 2'b10;

        for (int w = 0; w < cost + 20 && done_cnt == 0; w++) tick();
        tick();

        n_tests++;
        if (done_cnt != 1) begin
            n_fail++;
            $display("FAIL %s net_done_count: got %0d, required 1", name, done_cnt);
        end
        n_tests++;
        if (done_cyc != t_launch + cost) begin
            n_fail++;
            $display("FAIL %s net_done_cycle: got %0d, required %0d", name, done_cyc - t_launch, cost);
        end
        n_tests++;
        if (busy_at_done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy_at_done: got %0b/%0b, required 0", name, busy_at_done, busy);
        end
        n_tests++;
        if (nrec != nst || multi_err != 0) begin
            n_fail++;
            $display("FAIL %s start_count: got %0d (multi=%0d), required %0d", name, nrec, multi_err, nst);
        end
        for (int k = 0; k < nst && k < nrec; k++) begin
            n_tests++;
            if (rec_type[k] !== exp_type[k] || rec_cyc[k] != exp_cyc[k] ||
                rec_dir[k] !== exp_dir[k] || rec_idx[k] != 4'(exp_idx[k])) begin
                n_fail++;
                $display("FAIL %s start[%0d]: got type=%0d cyc=+%0d dir=%b idx=%0d, required type=%0d cyc=+%0d dir=%b idx=%0d",
                         name, k, rec_type[k], rec_cyc[k] - t_launch, rec_dir[k], rec_idx[k],
                         exp_type[k], exp_cyc[k] - t_launch, exp_dir[k], exp_idx[k]);
            end
        end
        n_tests++;
        if (aybz_azby !== final_dir || layer_idx !== 4'(n - 1)) begin
            n_fail++;
            $display("FAIL %s final_state: dir=%b idx=%0d, required dir=%b idx=%0d",
                     name, aybz_azby, layer_idx, final_dir, n - 1);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({conv_start, pool_start, dense_start, busy, net_done, timeout_err} !== 6'b0 ||
            layer_idx !== '0 || aybz_azby !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_values: starts=%b busy=%b done=%b err=%b idx=%0d dir=%b, required 000 0 0 0 0 01",
                     {conv_start, pool_start, dense_start}, busy, net_done, timeout_err, layer_idx, aybz_azby);
        end
        rst = 1'b0;
        tick();
        for (int i = 0; i < MAXL; i++) write_table(i, 2'($urandom_range(0, 3)));
        n_tests++;
        if (busy !== 1'b0 || aybz_azby !== 2'b01) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b dir=%b, required 0 01", busy, aybz_azby);
        end
    endtask

    task automatic test_bad_num();
        logic [LOGL:0] bad [2];
        bad[0] = '0;
        bad[1] = (LOGL+1)'(MAXL + 1);
        for (int i = 0; i < 2; i++) begin
            num_layers = bad[i];
            run_start  = 1'b1;
            tick();
            run_start  = 1'b0;
            tick();
            n_tests++;
            if (busy !== 1'b0 || conv_start || pool_start || dense_start) begin
                n_fail++;
                $display("FAIL bad_num_%0d: busy=%b, required 0", bad[i], busy);
            end
        end
    endtask

    task automatic test_basic();
        write_table(0, 2'b00);
        write_table(1, 2'b01);
        write_table(2, 2'b10);
        for (int i = 0; i < 3; i++) delays[i] = 10;
        run_network("basic", 3);
    endtask

    task automatic test_nop();
        write_table(0, 2'b01);
        write_table(1, 2'b11);
        write_table(2, 2'b01);
        for (int i = 0; i < 2; i++) delays[i] = $urandom_range(1, 12);
        run_network("nop", 3);
    endtask

    task automatic test_other_done();
        int t_launch;
        write_table(0, 2'b01);
        delays[0] = 0;
        clear_monitor();
        num_layers = 5'd1;
        run_start  = 1'b1;
        tick();
        run_start  = 1'b0;
        t_launch   = cyc;
        tick();
        tick();
        inj_conv = 1'b1;
        tick();
        inj_conv = 1'b0;
        inj_dense = 1'b1;
        tick();
        inj_dense = 1'b0;
        tick();
        n_tests++;
        if (busy !== 1'b1 || aybz_azby !== 2'b01 || done_cnt != 0 || timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL other_done_ignored: busy=%b dir=%b done=%0d err=%b, required 1 01 0 0",
                     busy, aybz_azby, done_cnt, timeout_err);
        end
        inj_pool = 1'b1;
        tick();
        inj_pool = 1'b0;
        for (int w = 0; w < 10 && done_cnt == 0; w++) tick();
        n_tests++;
        if (done_cnt != 1 || done_cyc != t_launch + 8 || aybz_azby !== 2'b10) begin
            n_fail++;
            $display("FAIL pool_done_advances: done=%0d at +%0d dir=%b, required 1 at +8 dir=10",
                     done_cnt, done_cyc - t_launch, aybz_azby);
        end
    endtask

    task automatic test_timeout();
        write_table(0, 2'b00);
        delays[0] = 0;
        clear_monitor();
        num_layers = 5'd1;
        run_start  = 1'b1;
        tick();
        run_start  = 1'b0;
        repeat (15) tick();
        n_tests++;
        if (busy !== 1'b1 || timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_early: busy=%b err=%b after 15 WAIT cycles, required 1 0", busy, timeout_err);
        end
        tick();
        n_tests++;
        if (busy !== 1'b0 || timeout_err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_error: busy=%b err=%b, required 0 1", busy, timeout_err);
        end
        write_table(0, 2'b01);
        repeat (3) tick();
        n_tests++;
        if (timeout_err !== 1'b1 || done_cnt != 0) begin
            n_fail++;
            $display("FAIL timeout_sticky: err=%b net_done=%0d, required 1 0", timeout_err, done_cnt);
        end
        delays[0] = 5;
        run_network("after_timeout", 1);
    endtask

    task automatic test_busy_ignore();
        int t_launch;
        write_table(0, 2'b10);
        write_table(1, 2'b00);
        delays[0] = 8;
        delays[1] = 4;
        clear_monitor();
        num_layers = 5'd2;
        run_start  = 1'b1;
        tick();
        run_start  = 1'b0;
        t_launch   = cyc;
        repeat (3) tick();
        run_start = 1'b1;
        cfg_we    = 1'b1;
        cfg_addr  = 4'd1;
        cfg_type  = 2'b01;
        tick();
        run_start = 1'b0;
        cfg_we    = 1'b0;
        for (int w = 0; w < 40 && done_cnt == 0; w++) tick();
        n_tests++;
        if (done_cnt != 1 || done_cyc != t_launch + 18 || nrec != 2 || rec_type[1] !== 2'b00 || rec_cyc[0] != t_launch) begin
            n_fail++;
            $display("FAIL busy_ignore: done=%0d at +%0d starts=%0d type1=%0d, required 1 at +18 2 0",
                     done_cnt, done_cyc - t_launch, nrec, rec_type[1]);
        end
        delays[0] = 3;
        delays[1] = 3;
        run_network("table_readback", 2);
    endtask

    task automatic test_reset_midrun();
        write_table(0, 2'b00);
        write_table(1, 2'b11);
        write_table(2, 2'b01);
        delays[0] = 4;
        delays[1] = 0;
        clear_monitor();
        num_layers = 5'd3;
        run_start  = 1'b1;
        tick();
        run_start  = 1'b0;
        for (int w = 0; w < 30 && nrec < 2; w++) tick();
        tick();
        n_tests++;
        if (layer_idx !== 4'd2 || busy !== 1'b1 || aybz_azby !== 2'b10) begin
            n_fail++;
            $display("FAIL pre_reset: idx=%0d busy=%b dir=%b, required 2 1 10", layer_idx, busy, aybz_azby);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({conv_start, pool_start, dense_start, busy, net_done, timeout_err} !== 6'b0 ||
            layer_idx !== '0 || aybz_azby !== 2'b01) begin
            n_fail++;
            $display("FAIL async_reset: busy=%b idx=%0d dir=%b, required 0 0 01", busy, layer_idx, aybz_azby);
        end
        repeat (2) tick();
        rst = 1'b0;
        tick();
        write_table(1, 2'b10);
        for (int i = 0; i < 3; i++) delays[i] = 3;
        run_network("after_reset", 3);
    endtask

    task automatic test_random();
        int n;
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) write_table(i, 2'($urandom_range(0, 3)));
            for (int i = 0; i < n; i++) delays[i] = $urandom_range(1, 12);
            run_network("random", n);
        end
        for (int i = 0; i < MAXL; i++) write_table(i, 2'($urandom_range(0, 2)));
        for (int i = 0; i < MAXL; i++) delays[i] = $urandom_range(1, 6);
        run_network("full_table", MAXL);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) delays[i] = 1;
        test_reset();
        test_bad_num();
        test_basic();
        test_nop();
        test_other_done();
        test_timeout();
        test_busy_ignore();
        test_reset_midrun();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule
